fifo_rd_stream: RTL

//  Read-domain drain engine of the async FIFO. Takes the raw write-domain Gray pointer and

---
 rtl/fifo_rd_stream.sv | 88 ++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain drain engine of the async FIFO.
// Synchronizes the write pointer, reads the 1-cycle-latency RAM and presents the words
// as a valid/ready stream through a 2-entry buffer. Also reports occupancy.
// Ports:
//   i_rd_clk / i_rd_rst   read clock, asynchronous active-low reset
//   i_wr_ptr_gray         raw write-domain Gray pointer (unsynchronized)
//   o_rd_ptr_gray         registered Gray read pointer back to the write domain
//   o_mem_rd_en/o_rd_addr RAM read strobe and address
//   i_mem_rd_data         RAM data, one cycle after the strobe
//   o_valid/o_data/i_ready output stream, pop = o_valid & i_ready
//   o_level/o_empty/o_almost_empty  words held in RAM, in flight and buffered
module fifo_rd_stream #(
    parameter int ADDR_SIZE  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  i_rd_clk,
    input  logic                  i_rd_rst,
    input  logic [ADDR_SIZE:0]    i_wr_ptr_gray,
    output logic [ADDR_SIZE:0]    o_rd_ptr_gray,
    output logic                  o_mem_rd_en,
    output logic [ADDR_SIZE-1:0]  o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [ADDR_SIZE:0]    o_level,
    output logic                  o_empty,
    output logic                  o_almost_empty
);
    localparam int P = ADDR_SIZE + 1;

    logic [ADDR_SIZE:0]    r_wr_sync1, r_wr_sync2, r_rd_bin;
    logic [ADDR_SIZE:0]    w_wr_bin, w_rd_bin_nxt;
    logic                  r_in_flight;
    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
    logic                  w_pop, w_mem_empty;
    logic [1:0]            w_cnt_kept, w_pending;

    always_comb begin
        w_wr_bin = '0;
        for (int i = 0; i < P; i++) w_wr_bin[i] = ^(r_wr_sync2 >> i);
    end

    // o_rd_ptr_gray always equals gray(r_rd_bin), so emptiness compares it directly
    assign w_mem_empty  = (o_rd_ptr_gray == r_wr_sync2);
    assign w_pop        = o_valid & i_ready;
    assign w_cnt_kept   = r_cnt - {1'b0, w_pop};
    // buffer slots that will be occupied once the in-flight word lands
    assign w_pending    = w_cnt_kept + {1'b0, r_in_flight};
    assign o_mem_rd_en  = !w_mem_empty && (w_pending <= 2'd1);
    assign w_rd_bin_nxt = r_rd_bin + P'(1);
    assign o_rd_addr    = r_rd_bin[ADDR_SIZE-1:0];
    assign o_valid      = (r_cnt != 2'd0);
    assign o_data       = r_buf0;
    assign o_level      = (w_wr_bin - r_rd_bin) + P'(r_in_flight) + P'(r_cnt);
    assign o_empty      = (o_level == '0);
    assign o_almost_empty = (o_level <= P'(AE_LEVEL));

    always_ff @(posedge i_rd_clk or negedge i_rd_rst) begin
        if (!i_rd_rst) begin
            r_wr_sync1    <= '0;
            r_wr_sync2    <= '0;
            r_rd_bin      <= '0;
            o_rd_ptr_gray <= '0;
            r_in_flight   <= 1'b0;
            r_cnt         <= 2'd0;
            r_buf0        <= '0;
            r_buf1        <= '0;
        end else begin
            r_wr_sync1  <= i_wr_ptr_gray;
            r_wr_sync2  <= r_wr_sync1;
            r_in_flight <= o_mem_rd_en;
            r_cnt       <= w_pending;
            if (o_mem_rd_en) begin
                r_rd_bin      <= w_rd_bin_nxt;
                o_rd_ptr_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
            end
            if (w_pop) r_buf0 <= r_buf1;
            // the arriving word joins the tail behind whatever survives this pop
            if (r_in_flight) begin
                if (w_cnt_kept == 2'd0) r_buf0 <= i_mem_rd_data;
                else r_buf1 <= i_mem_rd_data;
            end
        end
    end
endmodule
